// File: rtl/sib_address_gen.sv
// rtl/sib_address_gen.sv - SIB effective-address generator: disp collect, base/index read, sum
module sib_address_gen (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [1:0]  i_scale_factor,
  input  logic [2:0]  i_segment_reg_index,
  input  logic        i_index_reg_is_present,
  input  logic        i_base_reg_is_present,
  input  logic [2:0]  i_index_reg_index,
  input  logic [2:0]  i_base_reg_index,
  input  logic        i_displacement_size_1,
  input  logic        i_displacement_size_4,
  input  logic        i_effective_address_undefined,
  input  logic        i_disp_byte_valid,
  input  logic [7:0]  i_disp_byte,
  output logic        o_disp_byte_ready,
  output logic        o_reg_read_valid,
  output logic [2:0]  o_reg_read_index,
  input  logic [31:0] i_reg_read_data,
  output logic        o_ea_valid,
  input  logic        i_ea_ready,
  output logic [31:0] o_ea,
  output logic [2:0]  o_ea_segment_reg_index,
  output logic        o_ea_fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISP,
    S_READ_BASE,
    S_READ_INDEX,
    S_SUM,
    S_OUT
  } state_t;

  state_t      state;
  logic [1:0]  scale_q;
  logic        base_present_q;
  logic        index_present_q;
  logic [2:0]  base_index_q;
  logic [2:0]  index_index_q;
  logic        size_4_q;
  logic        undefined_q;
  logic [1:0]  byte_count_q;
  logic [31:0] disp_q;
  logic [31:0] base_value_q;
  logic [31:0] index_value;
  logic        disp_last_byte;

  assign index_value    = index_present_q ? i_reg_read_data : 32'd0;
  assign disp_last_byte = !size_4_q || (byte_count_q == 2'd3);

  // Read strobes and byte-ready are registered on the transition into the
  // state that owns them, so each is high for exactly that state's cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                  <= S_IDLE;
      o_ready                <= 1'b1;
      o_disp_byte_ready      <= 1'b0;
      o_reg_read_valid       <= 1'b0;
      o_reg_read_index       <= 3'd0;
      o_ea_valid             <= 1'b0;
      o_ea                   <= 32'd0;
      o_ea_segment_reg_index <= 3'd0;
      o_ea_fault             <= 1'b0;
      scale_q                <= 2'd0;
      base_present_q         <= 1'b0;
      index_present_q        <= 1'b0;
      base_index_q           <= 3'd0;
      index_index_q          <= 3'd0;
      size_4_q               <= 1'b0;
      undefined_q            <= 1'b0;
      byte_count_q           <= 2'd0;
      disp_q                 <= 32'd0;
      base_value_q           <= 32'd0;
    end else begin
      o_reg_read_valid <= 1'b0;
      o_reg_read_index <= 3'd0;
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            o_ready                <= 1'b0;
            scale_q                <= i_scale_factor;
            base_present_q         <= i_base_reg_is_present;
            index_present_q        <= i_index_reg_is_present;
            base_index_q           <= i_base_reg_index;
            index_index_q          <= i_index_reg_index;
            size_4_q               <= i_displacement_size_4;
            undefined_q            <= i_effective_address_undefined;
            byte_count_q           <= 2'd0;
            disp_q                 <= 32'd0;
            base_value_q           <= 32'd0;
            o_ea                   <= 32'd0;
            o_ea_segment_reg_index <= i_segment_reg_index;
            o_ea_fault             <= i_effective_address_undefined;
            if (i_displacement_size_1 || i_displacement_size_4) begin
              state             <= S_DISP;
              o_disp_byte_ready <= 1'b1;
            end else if (i_effective_address_undefined) begin
              state      <= S_OUT;
              o_ea_valid <= 1'b1;
            end else begin
              state            <= S_READ_BASE;
              o_reg_read_valid <= i_base_reg_is_present;
              o_reg_read_index <= i_base_reg_is_present ? i_base_reg_index : 3'd0;
            end
          end
        end

        S_DISP: begin
          if (i_disp_byte_valid) begin
            case (byte_count_q)
              2'd0:    disp_q[7:0]   <= i_disp_byte;
              2'd1:    disp_q[15:8]  <= i_disp_byte;
              2'd2:    disp_q[23:16] <= i_disp_byte;
              default: disp_q[31:24] <= i_disp_byte;
            endcase
            byte_count_q <= byte_count_q + 2'd1;
            if (disp_last_byte) begin
              o_disp_byte_ready <= 1'b0;
              if (!size_4_q) begin
                disp_q <= {{24{i_disp_byte[7]}}, i_disp_byte};
              end
              // Undefined operands still drain their bytes to keep the stream aligned.
              if (undefined_q) begin
                state      <= S_OUT;
                o_ea_valid <= 1'b1;
              end else begin
                state            <= S_READ_BASE;
                o_reg_read_valid <= base_present_q;
                o_reg_read_index <= base_present_q ? base_index_q : 3'd0;
              end
            end
          end
        end

        S_READ_BASE: begin
          state            <= S_READ_INDEX;
          o_reg_read_valid <= index_present_q;
          o_reg_read_index <= index_present_q ? index_index_q : 3'd0;
        end

        S_READ_INDEX: begin
          base_value_q <= base_present_q ? i_reg_read_data : 32'd0;
          state        <= S_SUM;
        end

        S_SUM: begin
          o_ea       <= base_value_q + (index_value << scale_q) + disp_q;
          o_ea_valid <= 1'b1;
          state      <= S_OUT;
        end

        S_OUT: begin
          if (i_ea_ready) begin
            o_ea_valid <= 1'b0;
            o_ready    <= 1'b1;
            state      <= S_IDLE;
          end
        end

        default: begin
          state             <= S_IDLE;
          o_ready           <= 1'b1;
          o_disp_byte_ready <= 1'b0;
          o_ea_valid        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sib_address_gen.sv
// tb/tb_sib_address_gen.sv - directed self-checking bench for sib_address_gen
module tb_sib_address_gen;

  localparam logic [2:0] SEG_SS = 3'd2;
  localparam logic [2:0] SEG_DS = 3'd3;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_scale_factor;
  logic [2:0]  i_segment_reg_index;
  logic        i_index_reg_is_present;
  logic        i_base_reg_is_present;
  logic [2:0]  i_index_reg_index;
  logic [2:0]  i_base_reg_index;
  logic        i_displacement_size_1;
  logic        i_displacement_size_4;
  logic        i_effective_address_undefined;
  logic        i_disp_byte_valid;
  logic [7:0]  i_disp_byte;
  logic        o_disp_byte_ready;
  logic        o_reg_read_valid;
  logic [2:0]  o_reg_read_index;
  logic [31:0] i_reg_read_data = 32'hBAD0_BAD0;
  logic        o_ea_valid;
  logic        i_ea_ready;
  logic [31:0] o_ea;
  logic [2:0]  o_ea_segment_reg_index;
  logic        o_ea_fault;

  logic [31:0] regs [8];
  int          cyc = 0;
  int          acc_cyc;
  int          strobes;
  int          bytes_taken;
  int          idx_bad;
  logic [7:0]  read_mask;
  int          compared = 0;
  int          mismatched = 0;
  int          lat;

  sib_address_gen dut (
    .clock                         (clock),
    .reset                         (reset),
    .i_valid                       (i_valid),
    .o_ready                       (o_ready),
    .i_scale_factor                (i_scale_factor),
    .i_segment_reg_index           (i_segment_reg_index),
    .i_index_reg_is_present        (i_index_reg_is_present),
    .i_base_reg_is_present         (i_base_reg_is_present),
    .i_index_reg_index             (i_index_reg_index),
    .i_base_reg_index              (i_base_reg_index),
    .i_displacement_size_1         (i_displacement_size_1),
    .i_displacement_size_4         (i_displacement_size_4),
    .i_effective_address_undefined (i_effective_address_undefined),
    .i_disp_byte_valid             (i_disp_byte_valid),
    .i_disp_byte                   (i_disp_byte),
    .o_disp_byte_ready             (o_disp_byte_ready),
    .o_reg_read_valid              (o_reg_read_valid),
    .o_reg_read_index              (o_reg_read_index),
    .i_reg_read_data               (i_reg_read_data),
    .o_ea_valid                    (o_ea_valid),
    .i_ea_ready                    (i_ea_ready),
    .o_ea                          (o_ea),
    .o_ea_segment_reg_index        (o_ea_segment_reg_index),
    .o_ea_fault                    (o_ea_fault)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Register file: data returned one cycle after the strobe, garbage otherwise.
  always @(posedge clock)
    i_reg_read_data <= o_reg_read_valid ? regs[o_reg_read_index] : 32'hBAD0_BAD0;

  always @(negedge clock) begin
    if (o_reg_read_valid) begin
      strobes   = strobes + 1;
      read_mask = read_mask | (8'd1 << o_reg_read_index);
    end else if (o_reg_read_index != 3'd0) begin
      idx_bad = idx_bad + 1;
    end
    if (i_disp_byte_valid && o_disp_byte_ready) bytes_taken = bytes_taken + 1;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared = compared + 1;
    assert (obs === exp) else begin
      mismatched = mismatched + 1;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"},
          {21'd0, o_ready, o_disp_byte_ready, o_reg_read_valid, o_reg_read_index,
           o_ea_valid, o_ea_fault, o_ea_segment_reg_index},
          {21'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0});
    check({tag, "_ea"}, o_ea, 32'd0);
  endtask

  task automatic start(input logic [1:0] sc, input logic [2:0] seg, input logic ip,
                       input logic bp, input logic [2:0] ii, input logic [2:0] bi,
                       input logic s1, input logic s4, input logic und);
    i_scale_factor                = sc;
    i_segment_reg_index           = seg;
    i_index_reg_is_present        = ip;
    i_base_reg_is_present         = bp;
    i_index_reg_index             = ii;
    i_base_reg_index              = bi;
    i_displacement_size_1         = s1;
    i_displacement_size_4         = s4;
    i_effective_address_undefined = und;
    i_valid                       = 1'b1;
    check("ready_at_accept", {31'd0, o_ready}, 32'd1);
    strobes     = 0;
    bytes_taken = 0;
    read_mask   = 8'd0;
    acc_cyc     = cyc;
    tick();
    // Scramble the request fields; they must be ignored after the accept.
    i_valid                       = 1'b0;
    i_scale_factor                = ~sc;
    i_segment_reg_index           = ~seg;
    i_index_reg_is_present        = ~ip;
    i_base_reg_is_present         = ~bp;
    i_index_reg_index             = ~ii;
    i_base_reg_index              = ~bi;
    i_displacement_size_1         = ~s1;
    i_displacement_size_4         = ~s4;
    i_effective_address_undefined = ~und;
  endtask

  task automatic feed_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) tick();
    i_disp_byte_valid = 1'b1;
    i_disp_byte       = b;
    n = 0;
    while (!o_disp_byte_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    i_disp_byte_valid = 1'b0;
    i_disp_byte       = 8'h5A;
  endtask

  task automatic wait_ea(output int latency);
    int n;
    n = 0;
    while (!o_ea_valid && n < 50) begin
      tick();
      n++;
    end
    latency = cyc - acc_cyc;
  endtask

  task automatic finish_ea;
    i_ea_ready = 1'b1;
    tick();
    i_ea_ready = 1'b0;
    check("ea_valid_drop", {31'd0, o_ea_valid}, 32'd0);
    check("ready_after_hs", {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    regs[0] = 32'h0000_1000;
    regs[1] = 32'h0000_0010;
    regs[2] = 32'h0000_0003;
    regs[3] = 32'h0000_0100;
    regs[4] = 32'hFFFF_FFFC;
    regs[5] = 32'h5555_0005;
    regs[6] = 32'h0000_0020;
    regs[7] = 32'h7777_0007;
    strobes = 0; bytes_taken = 0; idx_bad = 0; read_mask = 8'd0;
    reset = 1'b1; i_valid = 1'b0; i_ea_ready = 1'b0;
    i_disp_byte_valid = 1'b0; i_disp_byte = 8'h00;
    i_scale_factor = 2'd0; i_segment_reg_index = 3'd0;
    i_index_reg_is_present = 1'b0; i_base_reg_is_present = 1'b0;
    i_index_reg_index = 3'd0; i_base_reg_index = 3'd0;
    i_displacement_size_1 = 1'b0; i_displacement_size_4 = 1'b0;
    i_effective_address_undefined = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check_reset_outputs("reset");

    // EAX + ECX*4 + disp8(0xF0)
    start(2'd2, SEG_DS, 1'b1, 1'b1, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0);
    feed_byte(8'hF0, 0);
    wait_ea(lat);
    check("t1_latency", lat, 32'd5);
    check("t1_ea", o_ea, 32'h0000_1030);
    check("t1_seg", {29'd0, o_ea_segment_reg_index}, {29'd0, SEG_DS});
    check("t1_fault", {31'd0, o_ea_fault}, 32'd0);
    check("t1_strobes", strobes, 32'd2);
    check("t1_mask", {24'd0, read_mask}, 32'h03);
    finish_ea();

    // no base, EDX*8 + disp32
    start(2'd3, SEG_DS, 1'b1, 1'b0, 3'd2, 3'd5, 1'b0, 1'b1, 1'b0);
    feed_byte(8'h78, 0); feed_byte(8'h56, 0); feed_byte(8'h34, 0); feed_byte(8'h12, 0);
    wait_ea(lat);
    check("t2_latency", lat, 32'd8);
    check("t2_ea", o_ea, 32'h1234_5690);
    check("t2_strobes", strobes, 32'd1);
    check("t2_mask", {24'd0, read_mask}, 32'h04);
    finish_ea();

    // ESP + disp8 wraps past 2^32
    start(2'd0, SEG_SS, 1'b0, 1'b1, 3'd4, 3'd4, 1'b1, 1'b0, 1'b0);
    feed_byte(8'h08, 0);
    wait_ea(lat);
    check("t3_ea", o_ea, 32'h0000_0004);
    check("t3_seg", {29'd0, o_ea_segment_reg_index}, {29'd0, SEG_SS});
    check("t3_strobes", strobes, 32'd1);
    check("t3_mask", {24'd0, read_mask}, 32'h10);
    finish_ea();

    // undefined with disp8: one byte drained, no reads
    start(2'd1, SEG_DS, 1'b1, 1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 1'b1);
    feed_byte(8'h55, 0);
    i_disp_byte_valid = 1'b1;
    wait_ea(lat);
    tick();
    i_disp_byte_valid = 1'b0;
    check("t4_latency", lat, 32'd2);
    check("t4_bytes", bytes_taken, 32'd1);
    check("t4_fault", {31'd0, o_ea_fault}, 32'd1);
    check("t4_ea", o_ea, 32'd0);
    check("t4_strobes", strobes, 32'd0);
    finish_ea();

    // undefined without displacement
    start(2'd2, SEG_SS, 1'b1, 1'b1, 3'd4, 3'd3, 1'b0, 1'b0, 1'b1);
    wait_ea(lat);
    check("t5_latency", lat, 32'd1);
    check("t5_fault", {31'd0, o_ea_fault}, 32'd1);
    check("t5_ea", o_ea, 32'd0);
    check("t5_strobes", strobes, 32'd0);
    finish_ea();

    // gapped disp32 and a stalled downstream
    start(2'd1, SEG_DS, 1'b1, 1'b1, 3'd6, 3'd3, 1'b0, 1'b1, 1'b0);
    feed_byte(8'h41, 2); feed_byte(8'h00, 1); feed_byte(8'h00, 3); feed_byte(8'h00, 0);
    wait_ea(lat);
    check("t6_ea", o_ea, 32'h0000_0181);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_hold_valid", {31'd0, o_ea_valid}, 32'd1);
      check("t6_hold_ea", o_ea, 32'h0000_0181);
    end
    finish_ea();

    // reset mid-displacement, then a fresh disp32 (both size flags set)
    start(2'd0, SEG_DS, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    feed_byte(8'h11, 0); feed_byte(8'h22, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("t7_reset");
    start(2'd0, SEG_DS, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    feed_byte(8'hAA, 0); feed_byte(8'hBB, 0); feed_byte(8'hCC, 0); feed_byte(8'hDD, 0);
    wait_ea(lat);
    check("t7_latency", lat, 32'd8);
    check("t7_ea", o_ea, 32'hDDCC_BBAA);
    check("t7_bytes", bytes_taken, 32'd4);
    check("t7_strobes", strobes, 32'd0);
    finish_ea();

    check("idle_read_index_zero", idx_bad, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
